// File: rtl/io_dispatch_pkg.sv
// Shared types and helpers for the memory-mapped I/O dispatcher.
package io_dispatch_pkg;

  // Dispatcher control state: idle, or waiting on a RAM read.
  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    RAM_WAIT = 1'b1
  } dispState_t;

  // Page number that selects the data RAM.
  localparam int PAGE_RAM = 0;

  // Wait counter width; RAM_LAT is limited to 1..15.
  localparam int CNT_W = 4;

  // Width of the page field addr[addrW-1:ramAw+1]; bit ramAw sits between
  // the RAM offset and the page and takes no part in decoding.
  function automatic int pageWidth(input int addrW, input int ramAw);
    return addrW - ramAw - 1;
  endfunction

endpackage

// File: rtl/io_page_decode.sv
// Combinational page decoder: RAM page, peripheral page or unmapped page.
module io_page_decode
  import io_dispatch_pkg::*;
#(
  parameter int PAGE_W = 8,
  parameter int NUM_CH = 4
) (
  input  logic [PAGE_W-1:0] page,
  output logic              isRam,
  output logic              isPer,
  output logic              unmapped,
  output logic [NUM_CH-1:0] chSel
);

  localparam logic [PAGE_W-1:0] MAX_PAGE = PAGE_W'(NUM_CH);

  // Compare the whole field unsigned so large pages can never alias a channel.
  assign isRam    = (page == PAGE_W'(PAGE_RAM));
  assign unmapped = (page > MAX_PAGE);
  assign isPer    = ~isRam & ~unmapped;

  // Channel gi answers page gi+1.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : gChSel
      assign chSel[gi] = (page == PAGE_W'(gi + 1));
    end
  endgenerate

endmodule

// File: rtl/io_dispatch.sv
// Registered memory-mapped I/O dispatcher: core <-> data RAM + peripherals.
module io_dispatch
  import io_dispatch_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int RAM_AW  = 15,
  parameter int NUM_CH  = 4,
  parameter int RAM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic                     we_in,
  input  logic [ADDR_W-1:0]        addr_in,
  input  logic [DATA_W-1:0]        wdata_in,
  output logic [DATA_W-1:0]        rdata_out,
  output logic                     ready,
  output logic                     err_unmapped,
  output logic                     ram_we,
  output logic [RAM_AW-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_wdata,
  input  logic [DATA_W-1:0]        ram_rdata,
  input  logic [NUM_CH*DATA_W-1:0] per_rdata,
  output logic [NUM_CH-1:0]        per_rd_stb,
  output logic [NUM_CH-1:0]        per_we
);

  localparam int PAGE_W = pageWidth(ADDR_W, RAM_AW);

  logic [PAGE_W-1:0] page;
  logic              unusedAddrBit;
  logic              isRam, isPer, unmapped;
  logic [NUM_CH-1:0] chSel;
  logic [DATA_W-1:0] selData;

  dispState_t        stateReg, stateNext;
  logic [CNT_W-1:0]  cntReg, cntNext;
  logic              errPendReg, errPendNext;

  logic              readyNext, errNext, ramWeNext;
  logic [NUM_CH-1:0] perWeNext, perRdStbNext;
  logic [RAM_AW-1:0] ramAddrNext;
  logic [DATA_W-1:0] ramWdataNext, rdataNext;

  assign page          = addr_in[ADDR_W-1:RAM_AW+1];
  assign unusedAddrBit = addr_in[RAM_AW];

  io_page_decode #(
    .PAGE_W (PAGE_W),
    .NUM_CH (NUM_CH)
  ) uDecode (
    .page     (page),
    .isRam    (isRam),
    .isPer    (isPer),
    .unmapped (unmapped),
    .chSel    (chSel)
  );

  // Select the addressed peripheral's read word (chSel is one-hot or zero).
  always_comb begin
    selData = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (chSel[k]) selData = selData | per_rdata[k*DATA_W +: DATA_W];
    end
  end

  // Next-state and next-output logic; every output is a pulse unless set here.
  always_comb begin
    stateNext    = stateReg;
    cntNext      = cntReg;
    errPendNext  = errPendReg;
    readyNext    = 1'b0;
    errNext      = 1'b0;
    ramWeNext    = 1'b0;
    perWeNext    = '0;
    perRdStbNext = '0;
    ramAddrNext  = ram_addr;
    ramWdataNext = ram_wdata;
    rdataNext    = rdata_out;
    unique case (stateReg)
      IDLE: begin
        if (req) begin
          ramAddrNext  = addr_in[RAM_AW-1:0];
          ramWdataNext = wdata_in;
          if (isPer) begin
            readyNext = 1'b1;
            if (we_in) begin
              perWeNext = chSel;
            end else begin
              perRdStbNext = chSel;
              rdataNext    = selData;
            end
          end else if (isRam | unmapped) begin
            // Unmapped pages fall back to RAM and raise the error flag.
            if (we_in) begin
              ramWeNext = 1'b1;
              readyNext = 1'b1;
              errNext   = unmapped;
            end else begin
              stateNext   = RAM_WAIT;
              cntNext     = CNT_W'(RAM_LAT);
              errPendNext = unmapped;
            end
          end
        end
      end
      RAM_WAIT: begin
        // ram_rdata is valid in the last wait cycle; requests are ignored here.
        if (cntReg == CNT_W'(1)) begin
          rdataNext   = ram_rdata;
          readyNext   = 1'b1;
          errNext     = errPendReg;
          errPendNext = 1'b0;
          cntNext     = '0;
          stateNext   = IDLE;
        end else begin
          cntNext = cntReg - CNT_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, counter and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg     <= IDLE;
      cntReg       <= '0;
      errPendReg   <= 1'b0;
      ready        <= 1'b0;
      err_unmapped <= 1'b0;
      ram_we       <= 1'b0;
      per_we       <= '0;
      per_rd_stb   <= '0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      rdata_out    <= '0;
    end else begin
      stateReg     <= stateNext;
      cntReg       <= cntNext;
      errPendReg   <= errPendNext;
      ready        <= readyNext;
      err_unmapped <= errNext;
      ram_we       <= ramWeNext;
      per_we       <= perWeNext;
      per_rd_stb   <= perRdStbNext;
      ram_addr     <= ramAddrNext;
      ram_wdata    <= ramWdataNext;
      rdata_out    <= rdataNext;
    end
  end

endmodule

// File: tb/tb_io_dispatch.sv
// Randomised bench for io_dispatch against a transaction-level reference model.
module tb_io_dispatch;

  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 16;
  localparam int RAM_AW  = 15;
  localparam int NUM_CH  = 4;
  localparam int RAM_LAT = 3;
  localparam int RAM_SZ  = 1 << RAM_AW;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     req;
  logic                     we_in;
  logic [ADDR_W-1:0]        addr_in;
  logic [DATA_W-1:0]        wdata_in;
  logic [DATA_W-1:0]        rdata_out;
  logic                     ready;
  logic                     err_unmapped;
  logic                     ram_we;
  logic [RAM_AW-1:0]        ram_addr;
  logic [DATA_W-1:0]        ram_wdata;
  logic [DATA_W-1:0]        ram_rdata;
  logic [NUM_CH*DATA_W-1:0] per_rdata;
  logic [NUM_CH-1:0]        per_rd_stb;
  logic [NUM_CH-1:0]        per_we;

  int assertCnt = 0;
  int failCnt   = 0;

  // Reference model state: RAM contents and last completed read value.
  logic [DATA_W-1:0] refMem [0:RAM_SZ-1];
  logic [DATA_W-1:0] lastRdata;

  always #5 clk = ~clk;

  io_dispatch #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RAM_AW  (RAM_AW),
    .NUM_CH  (NUM_CH),
    .RAM_LAT (RAM_LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .we_in        (we_in),
    .addr_in      (addr_in),
    .wdata_in     (wdata_in),
    .rdata_out    (rdata_out),
    .ready        (ready),
    .err_unmapped (err_unmapped),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .per_rdata    (per_rdata),
    .per_rd_stb   (per_rd_stb),
    .per_we       (per_we)
  );

  function automatic logic [DATA_W-1:0] seedVal(input int a);
    return DATA_W'(a * 40503 + 16'h5A5A);
  endfunction

  // Data RAM device: read data appears RAM_LAT-1 clocks after the address.
  logic [DATA_W-1:0] devMem  [0:RAM_SZ-1];
  logic [DATA_W-1:0] ramPipe [0:RAM_LAT-2];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RAM_SZ; i++) devMem[i] <= seedVal(i);
    end else if (ram_we) begin
      devMem[ram_addr] <= ram_wdata;
    end
    ramPipe[0] <= devMem[ram_addr];
    for (int i = 1; i < RAM_LAT - 1; i++) ramPipe[i] <= ramPipe[i-1];
  end
  assign ram_rdata = ramPipe[RAM_LAT-2];

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < RAM_SZ; i++) refMem[i] = seedVal(i);
    lastRdata = '0;
  endtask

  task automatic checkZeroCtrl(input string tag);
    checkVal(tag, {ready, err_unmapped, ram_we, per_we, per_rd_stb}, 64'd0);
  endtask

  task automatic checkResetState();
    checkZeroCtrl("rst_ctrl");
    checkVal("rst_rdata", rdata_out, 64'd0);
    checkVal("rst_ram_addr", ram_addr, 64'd0);
    checkVal("rst_ram_wdata", ram_wdata, 64'd0);
  endtask

  // Idle for n cycles with req low; nothing may pulse and rdata_out must hold.
  task automatic idleCycles(input int n);
    req = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkZeroCtrl("idle_ctrl");
      checkVal("idle_rdata_hold", rdata_out, lastRdata);
    end
  endtask

  // One core access, called at a negedge. Returns at the negedge of the ready
  // cycle with req still driven, so the caller may issue the next access
  // back-to-back or go idle.
  task automatic runTxn(input bit we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input bit junk);
    int                page;
    int                lat;
    bit                perPage;
    bit                unm;
    logic [NUM_CH-1:0] expPerWe;
    logic [NUM_CH-1:0] expStb;
    bit                expRamWe;
    logic [RAM_AW-1:0] off;
    page     = int'(a[ADDR_W-1:RAM_AW+1]);
    off      = a[RAM_AW-1:0];
    perPage  = (page >= 1) && (page <= NUM_CH);
    unm      = page > NUM_CH;
    expPerWe = '0;
    expStb   = '0;
    expRamWe = 1'b0;
    lat      = 1;
    if (perPage) begin
      if (we) expPerWe = NUM_CH'(1 << (page - 1));
      else begin
        expStb    = NUM_CH'(1 << (page - 1));
        lastRdata = per_rdata[(page-1)*DATA_W +: DATA_W];
      end
    end else if (we) begin
      expRamWe    = 1'b1;
      refMem[off] = d;
    end else begin
      lat       = RAM_LAT + 1;
      lastRdata = refMem[off];
    end
    req      = 1'b1;
    we_in    = we;
    addr_in  = a;
    wdata_in = d;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      per_rdata = {$urandom, $urandom};
      if (k < lat) begin
        checkZeroCtrl("busy_ctrl");
        if (junk) begin
          req      = 1'b1;
          we_in    = 1'($urandom);
          addr_in  = ADDR_W'($urandom);
          wdata_in = DATA_W'($urandom);
        end else begin
          req = 1'b0;
        end
      end else begin
        $display("txn we=%0d addr=0x%06h data=0x%04h page=%0d lat=%0d rdata=0x%04h",
                 we, a, d, page, lat, rdata_out);
        checkVal("ready", ready, 64'd1);
        checkVal("err_unmapped", err_unmapped, 64'(unm));
        checkVal("ram_we", ram_we, 64'(expRamWe));
        checkVal("per_we", per_we, 64'(expPerWe));
        checkVal("per_rd_stb", per_rd_stb, 64'(expStb));
        checkVal("rdata_out", rdata_out, 64'(lastRdata));
        checkVal("ram_addr", ram_addr, 64'(off));
        checkVal("ram_wdata", ram_wdata, 64'(d));
      end
    end
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    logic [7:0]        pg;
    int                r;
    req       = 1'b0;
    we_in     = 1'b0;
    addr_in   = '0;
    wdata_in  = '0;
    per_rdata = '0;
    reset     = 1'b1;
    resetModel();
    repeat (3) @(negedge clk);
    checkResetState();
    reset = 1'b0;

    // Reset asserted for three cycles in the middle of a RAM read.
    req     = 1'b1;
    we_in   = 1'b0;
    addr_in = 24'h000010;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkResetState();
    reset = 1'b0;
    resetModel();
    idleCycles(6);

    // RAM write.
    runTxn(1'b1, 24'h001234, 16'hBEEF, 1'b0);
    idleCycles(1);
    // RAM read with a stray request held during the wait.
    runTxn(1'b1, 24'h000010, 16'h5A5A, 1'b0);
    runTxn(1'b0, 24'h000010, 16'h0000, 1'b1);
    idleCycles(1);
    // Peripheral read from channel 2.
    per_rdata = '0;
    per_rdata[2*DATA_W +: DATA_W] = 16'h00C3;
    runTxn(1'b0, 24'h030000, 16'h0000, 1'b0);
    idleCycles(1);
    // Unmapped pages alias to RAM, including pages whose low bits match a channel.
    runTxn(1'b0, 24'h070010, 16'h0000, 1'b0);
    runTxn(1'b1, 24'h110020, 16'hA55A, 1'b0);
    runTxn(1'b0, 24'h110020, 16'h0000, 1'b0);
    idleCycles(1);
    // Back-to-back peripheral write then RAM read with req held high.
    runTxn(1'b1, 24'h020000, 16'h1111, 1'b0);
    runTxn(1'b0, 24'h001234, 16'h0000, 1'b0);
    idleCycles(2);

    // Randomised accesses.
    for (int t = 0; t < 400; t++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)      pg = 8'd0;
      else if (r < 8) pg = 8'($urandom_range(1, NUM_CH));
      else if (r < 9) pg = 8'($urandom_range(NUM_CH + 1, 15));
      else            pg = 8'($urandom_range(16, 255));
      a = ADDR_W'($urandom);
      a[ADDR_W-1:RAM_AW+1] = pg;
      if ($urandom_range(0, 1) == 1) a[RAM_AW-1:0] = RAM_AW'($urandom_range(0, 31));
      runTxn(1'($urandom), a, DATA_W'($urandom), 1'($urandom));
      r = int'($urandom_range(0, 2));
      if (r > 0) idleCycles(r);
    end
    idleCycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
